// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with write FIFO, baud divider and run-time frame format.
// Words are serialised LSB-first, back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [3:0]                    dlen,
    input  logic [1:0]                    par_mode,
    input  logic                          two_stop,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
    localparam logic [3:0] DW4 = DATA_W[3:0];

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop, tick, tx_n;
    logic [DIV_W-1:0]  cnt, cnt_n, fdiv;
    logic [3:0]        idx, idx_n, fn, n;
    logic [DATA_W-1:0] sh, sh_n, head, mask;
    logic              fpar_en, fpar, ftwo;

    assign n       = (dlen < 4'd5) ? 4'd5 : (dlen > DW4) ? DW4 : dlen;
    assign mask    = {DATA_W{1'b1}} >> (DW4 - n);
    assign head    = mem[rd_ptr];
    assign s_ready = fifo_count < FULL;
    assign push    = s_valid && s_ready;
    assign busy    = state != IDLE;
    assign tick    = cnt == fdiv;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= s_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Frame format is frozen at the pop so config changes only affect later frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fdiv    <= '0;
            fn      <= 4'd5;
            fpar_en <= 1'b0;
            fpar    <= 1'b0;
            ftwo    <= 1'b0;
        end else if (pop) begin
            fdiv    <= baud_div;
            fn      <= n;
            fpar_en <= ^par_mode;
            fpar    <= (^(head & mask)) ^ par_mode[0];
            ftwo    <= two_stop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            tx    <= tx_n;
        end
    end

    // tx_n is the level of the bit period being entered, so tx stays registered.
    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + DIV_W'(1);
        idx_n   = idx;
        sh_n    = sh;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START: if (tick) begin
                state_n = DATA;
                idx_n   = '0;
                tx_n    = sh[0];
            end
            DATA: if (tick) begin
                if (idx == fn - 4'd1) begin
                    state_n = fpar_en ? PARITY : STOP;
                    tx_n    = fpar_en ? fpar : 1'b1;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + 4'd1;
                    sh_n  = sh >> 1;
                    tx_n  = sh[1];
                end
            end
            PARITY: if (tick) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
            STOP: if (tick) begin
                if (ftwo && idx == '0) idx_n = 4'd1;
                else if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    tx_n    = 1'b0;
                end else state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (pop) sh_n = head;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal baud-rate divider, a write FIFO and run-time frame configuration: 5..DATA_W data bits, none/odd/even parity, and 1 or 2 stop bits. It sits between the sensor/data-formatting logic and the serial pin. Callers push words with a valid/ready handshake, and the block serialises them LSB-first, back-to-back, with no idle gap while the FIFO holds data.

## Interface
- DATA_W, 8, maximum data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, number of FIFO entries; power of 2, at least 2.
- DIV_W, 16, width of the baud divisor.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- baud_div  in  DIV_W  bit period in clocks minus 1; 0 gives 1 clock per bit.
- dlen  in  4  data bits per frame; values below 5 act as 5, values above DATA_W act as DATA_W.
- par_mode  in  2  00 or 11 = no parity, 01 = odd, 10 = even.
- two_stop  in  1  0 = 1 stop bit, 1 = 2 stop bits.
- s_data  in  DATA_W  word to send; only bits [n-1:0] are transmitted, where n is the effective dlen.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept a word.
- tx  out  1  serial line, registered; idles high.
- busy  out  1  high whenever the FSM is not in IDLE.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of words stored.

## Operation
- **Reset values:** tx=1, busy=0, s_ready=1, fifo_count=0, FSM=IDLE, divider=0, FIFO flushed.
- **Reset mid-frame:** tx returns high immediately (asynchronously). The partial frame and all FIFO contents are discarded.
- **FIFO write:** occurs on a clock edge with s_valid && s_ready.
  - s_ready = (fifo_count < FIFO_DEPTH). There is no write-through when full, even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** tx=1. When fifo_count != 0: pop the head word and latch baud_div, the effective dlen, par_mode and two_stop into frame registers. Compute the parity bit from the n data bits. Go to START.
  - **START:** tx=0 for one bit period, then go to DATA.
  - **DATA:** send bits 0..n-1, LSB first, one bit period each. Then go to PARITY if parity is enabled, otherwise STOP.
  - **PARITY:** send one bit period.
    - Odd: parity = ~^data[n-1:0], so the total number of ones is odd.
    - Even: parity = ^data[n-1:0].
  - **STOP:** tx=1 for 1 or 2 bit periods. At the end: if the FIFO is non-empty, pop the next word and go directly to START with no idle bit; otherwise go to IDLE.
- **Config changes:** changes to config inputs during a frame have no effect until the next frame's latch point.
- **Bit-period counter:** counts 0..latched baud_div. The bit advances when the counter equals baud_div, and the counter then wraps to 0.
- **Frame length:** (1 + n + p + s) × (baud_div + 1) clocks, where p ∈ {0,1} is the parity bit and s ∈ {1,2} is the stop-bit count.

## Timing
- **Write to start bit:** a word written at edge E0 into an empty FIFO while idle makes fifo_count=1 after E0. tx falls and busy rises at E1, and the FIFO pop also occurs at E1. tx stays low for baud_div+1 clocks.
- **tx is registered:** each bit value appears on the edge that enters its bit period and holds for exactly baud_div+1 clocks.
- **Back-to-back frames:** the start bit of frame k+1 begins on the edge immediately after the last stop-bit clock of frame k.
- **Return to idle:** busy falls on the edge that leaves STOP with an empty FIFO.
- **s_ready after a pop:** s_ready rises one edge after a pop from a full FIFO.
- **fifo_count:** updates on the edge of each push or pop.

## Test plan
- **8N1, single word:** baud_div=3, dlen=8, par_mode=00, two_stop=0, write 0xA5 → tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks. Frame is 40 clocks. busy=1 throughout, then busy=0.
- **7E2:** dlen=7, par_mode=10, two_stop=1, baud_div=1, write 0x55 → data bits 1,0,1,0,1,0,1, parity 0, two stop bits. Frame is 22 clocks.
- **8O1, all zeros:** dlen=8, par_mode=01, write 0x00 → parity bit 1. Then write 0xFF → parity bit 1.
- **FIFO fill and back-to-back:** with DEPTH=4, hold s_valid for 6 cycles while idle, baud_div=0, 8N1.
  - First word is popped at once, so 5 words are accepted.
  - s_ready goes low once fifo_count=4; the 6th write is refused.
  - 5 consecutive 10-clock frames are sent with no idle gap.
- **Reset mid-frame:** assert rst during DATA of the 2nd of 3 queued frames → tx=1, busy=0, fifo_count=0 immediately. No further frames after rst deasserts.
- **Boundaries:**
  - baud_div=0, dlen=3 → 5 data bits sent.
  - dlen=15 → DATA_W bits sent.
  - Changing par_mode mid-frame does not alter the current frame's parity.
